// File: rtl/sseg_pkg.sv
// Shared types and defaults for the seven-segment digit scanner.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
package sseg_pkg;

  typedef logic [3:0] nibble_t;

  localparam int SSEG_NUM_DIGITS   = 4;
  localparam int SSEG_PRESCALE     = 1000;
  localparam int SSEG_BLANK_CYCLES = 16;

  // Width of the in-slot cycle counter; at least one bit.
  function automatic int sseg_cnt_width(input int prescale);
    return (prescale > 1) ? $clog2(prescale) : 1;
  endfunction

  // Width of the digit index; a single-digit display still gets one bit.
  function automatic int sseg_idx_width(input int num_digits);
    return (num_digits > 1) ? $clog2(num_digits) : 1;
  endfunction

endpackage

// File: rtl/sseg_slot_timer.sv
// Slot timer: counts cycles within a digit slot and steps the digit index.
// Latency: outputs decode combinationally from cnt/idx registers.
// Backpressure: none, free-running.
module sseg_slot_timer
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS   = SSEG_NUM_DIGITS,
  parameter int PRESCALE     = SSEG_PRESCALE,
  parameter int BLANK_CYCLES = SSEG_BLANK_CYCLES,
  parameter int IDX_W        = sseg_idx_width(NUM_DIGITS)
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [IDX_W-1:0] idx_o,
  output logic             blank_phase_o,
  output logic             frame_end_o
);

  localparam int CNT_W = sseg_cnt_width(PRESCALE);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             slot_last;
  logic             digit_last;

  assign slot_last  = (cnt_q == CNT_W'(PRESCALE - 1));
  assign digit_last = (idx_q == IDX_W'(NUM_DIGITS - 1));

  // Advance the cycle count; at the end of a slot move on to the next digit.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (slot_last) begin
      cnt_d = '0;
      idx_d = digit_last ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Timer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  assign idx_o         = idx_q;
  assign blank_phase_o = (int'(cnt_q) < BLANK_CYCLES);
  assign frame_end_o   = slot_last && digit_last;

endmodule

// File: rtl/sseg_digit_scanner.sv
// Time-multiplexes a multi-digit hex value onto one 7-segment bus with anti-ghost blanking.
// Latency: outputs are combinational from state; an accepted value shows from the next frame (1..NUM_DIGITS*PRESCALE cycles).
// Backpressure: value_ready drops while a value waits in the shadow buffer for the frame boundary.
module sseg_digit_scanner
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS   = SSEG_NUM_DIGITS,
  parameter int PRESCALE     = SSEG_PRESCALE,
  parameter int BLANK_CYCLES = SSEG_BLANK_CYCLES
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    value_valid,
  output logic                    value_ready,
  input  logic                    lz_suppress,
  output logic [3:0]              digit,
  output logic                    digit_en,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_end
);

  localparam int IDX_W = sseg_idx_width(NUM_DIGITS);
  localparam int VAL_W = 4 * NUM_DIGITS;

  logic [IDX_W-1:0]      idx;
  logic                  blank_phase;
  logic [VAL_W-1:0]      disp_q, disp_d;
  logic [VAL_W-1:0]      shadow_q, shadow_d;
  logic                  pending_q, pending_d;
  logic                  accept;
  logic [NUM_DIGITS-1:0] upper_zero;
  logic                  suppressed;

  sseg_slot_timer #(
    .NUM_DIGITS   (NUM_DIGITS),
    .PRESCALE     (PRESCALE),
    .BLANK_CYCLES (BLANK_CYCLES),
    .IDX_W        (IDX_W)
  ) u_timer (
    .clk           (clk),
    .rst_n         (rst_n),
    .idx_o         (idx),
    .blank_phase_o (blank_phase),
    .frame_end_o   (frame_end)
  );

  // Ready is low exactly while the shadow holds an uncommitted value, so accept and commit never collide.
  assign value_ready = ~pending_q;
  assign accept      = value_valid && !pending_q;

  // Capture new values into the shadow; swap into the display only at the frame boundary.
  always_comb begin
    disp_d    = disp_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    if (accept) begin
      shadow_d  = value_in;
      pending_d = 1'b1;
    end
    if (frame_end && pending_q) begin
      disp_d    = shadow_q;
      pending_d = 1'b0;
    end
  end

  // Display, shadow and pending registers; reset drops any pending value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_q    <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      disp_q    <= disp_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
    end
  end

  // upper_zero[i]: every displayed nibble at position i or above is zero.
  always_comb begin
    upper_zero = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      upper_zero[i] = ((disp_q >> (4 * i)) == '0);
    end
  end

  assign suppressed = lz_suppress && (idx != '0) && upper_zero[idx];
  assign digit      = disp_q[4*int'(idx) +: 4];

  // Light the current anode only after the blanking window and when not a suppressed leading zero.
  always_comb begin
    an_n     = '1;
    digit_en = 1'b0;
    if (!blank_phase && !suppressed) begin
      digit_en  = 1'b1;
      an_n[idx] = 1'b0;
    end
  end

endmodule

// File: tb/tb_sseg_digit_scanner.sv
// Directed bench for sseg_digit_scanner with NUM_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2.
// Latency: frame is 32 cycles; cycle 0 is the first cycle after reset release.
// Backpressure: exercises value_valid held high across a not-ready window.
module tb_sseg_digit_scanner;

  localparam int ND = 4;
  localparam int PS = 8;
  localparam int BC = 2;
  localparam int FRAME = ND * PS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [15:0]   value_in = '0;
  logic          value_valid = 1'b0;
  logic          value_ready;
  logic          lz_suppress = 1'b0;
  logic [3:0]    digit;
  logic          digit_en;
  logic [ND-1:0] an_n;
  logic          frame_end;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  sseg_digit_scanner #(
    .NUM_DIGITS   (ND),
    .PRESCALE     (PS),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .value_in    (value_in),
    .value_valid (value_valid),
    .value_ready (value_ready),
    .lz_suppress (lz_suppress),
    .digit       (digit),
    .digit_en    (digit_en),
    .an_n        (an_n),
    .frame_end   (frame_end)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] val;
    logic        lz;
    logic [15:0] an;   // expected an_n in the SHOW phase, slot s in bits [4s+3:4s]
    logic [3:0]  en;   // expected digit_en in the SHOW phase, slot s in bit s
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int t);
    while (cyc < t) tick();
  endtask

  task automatic goto_pos(input int pos);
    while ((cyc % FRAME) != pos) tick();
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
  endtask

  initial begin
    vecs[0] = '{val: 16'h1A3F, lz: 1'b0, an: 16'h7BDE, en: 4'b1111};
    vecs[1] = '{val: 16'h0042, lz: 1'b1, an: 16'hFFDE, en: 4'b0011};
    vecs[2] = '{val: 16'h0000, lz: 1'b1, an: 16'hFFFE, en: 4'b0001};
    vecs[3] = '{val: 16'h0400, lz: 1'b1, an: 16'hFBDE, en: 4'b0111};
    vecs[4] = '{val: 16'h0400, lz: 1'b0, an: 16'h7BDE, en: 4'b1111};
    vecs[5] = '{val: 16'h8000, lz: 1'b1, an: 16'h7BDE, en: 4'b1111};

    // ---- reset state while held low
    #12;
    chk("rst_an_n", an_n, 4'hF);
    chk("rst_digit_en", digit_en, 1'b0);
    chk("rst_digit", digit, 4'h0);
    chk("rst_ready", value_ready, 1'b1);
    chk("rst_frame_end", frame_end, 1'b0);
    release_reset();

    // ---- free-running timing after reset
    chk("c0_an_n", an_n, 4'hF);
    goto(1);  chk("c1_an_n", an_n, 4'hF);
    goto(2);  chk("c2_an_n", an_n, 4'hE); chk("c2_digit", digit, 4'h0); chk("c2_en", digit_en, 1'b1);
    goto(7);  chk("c7_an_n", an_n, 4'hE);
    goto(8);  chk("c8_an_n", an_n, 4'hF);
    goto(10); chk("c10_an_n", an_n, 4'hD);
    goto(30); chk("c30_fe", frame_end, 1'b0);
    goto(31); chk("c31_fe", frame_end, 1'b1);
    goto(32); chk("c32_fe", frame_end, 1'b0);
    goto(63); chk("c63_fe", frame_end, 1'b1);

    // ---- table-driven loads; each walks one full displayed frame
    for (int v = 0; v < 6; v++) begin
      int f;
      logic [15:0] val;
      logic [15:0] an_exp;
      logic [3:0]  en_exp;
      val    = vecs[v].val;
      an_exp = vecs[v].an;
      en_exp = vecs[v].en;
      lz_suppress = vecs[v].lz;
      goto_pos(5);
      value_in = val;
      value_valid = 1'b1;
      tick();
      value_valid = 1'b0;
      value_in = 16'hDEAD;
      chk("ld_ready_low", value_ready, 1'b0);
      goto_pos(FRAME - 1);
      chk("ld_fe", frame_end, 1'b1);
      chk("ld_ready_at_fe", value_ready, 1'b0);
      tick();
      chk("ld_ready_high", value_ready, 1'b1);
      f = cyc;
      for (int s = 0; s < ND; s++) begin
        goto(f + s * PS + 1);
        chk("blank_an_n", an_n, 4'hF);
        chk("blank_en", digit_en, 1'b0);
        chk("blank_digit", digit, val[4*s +: 4]);
        goto(f + s * PS + 5);
        chk("show_an_n", an_n, an_exp[4*s +: 4]);
        chk("show_en", digit_en, en_exp[s]);
        chk("show_digit", digit, val[4*s +: 4]);
      end
    end

    // ---- reset mid-slot 2 with a value pending
    lz_suppress = 1'b0;
    goto_pos(4);
    value_in = 16'h9999;
    value_valid = 1'b1;
    tick();
    value_valid = 1'b0;
    goto(cyc - 5 + 20);
    chk("mr_pending", value_ready, 1'b0);
    chk("mr_an_before", an_n, 4'hB);
    rst_n = 1'b0;
    #2;
    chk("mr_an_n", an_n, 4'hF);
    chk("mr_en", digit_en, 1'b0);
    chk("mr_digit", digit, 4'h0);
    chk("mr_ready", value_ready, 1'b1);
    chk("mr_fe", frame_end, 1'b0);
    release_reset();
    goto(5);  chk("mr_s0_digit", digit, 4'h0); chk("mr_s0_an", an_n, 4'hE);
    goto(31); chk("mr_ready_fe", value_ready, 1'b1);
    goto(FRAME + 29); chk("mr_s3_digit", digit, 4'h0); chk("mr_s3_an", an_n, 4'h7);

    // ---- accept on the exact frame_end cycle
    goto(95);
    chk("fa_fe", frame_end, 1'b1);
    chk("fa_ready", value_ready, 1'b1);
    value_in = 16'hBEEF;
    value_valid = 1'b1;
    tick();
    value_valid = 1'b0;
    chk("fa_accepted", value_ready, 1'b0);
    goto(101); chk("fa_no_commit", digit, 4'h0);
    goto(127); chk("fa_fe2", frame_end, 1'b1);
    goto(133); chk("fa_s0_digit", digit, 4'hF); chk("fa_s0_an", an_n, 4'hE);
    goto(157); chk("fa_s3_digit", digit, 4'hB); chk("fa_s3_an", an_n, 4'h7);

    // ---- valid held across not-ready with a changing value
    goto(165);
    value_in = 16'h1234;
    value_valid = 1'b1;
    tick();
    value_in = 16'h5678;
    chk("hv_ready_low", value_ready, 1'b0);
    goto(191); chk("hv_ready_fe", value_ready, 1'b0); chk("hv_fe", frame_end, 1'b1);
    tick();    chk("hv_ready_rise", value_ready, 1'b1);
    tick();
    value_valid = 1'b0;
    chk("hv_second_acc", value_ready, 1'b0);
    goto(197); chk("hv_f1_s0", digit, 4'h4);
    goto(221); chk("hv_f1_s3", digit, 4'h1);
    goto(229); chk("hv_f2_s0", digit, 4'h8);
    goto(253); chk("hv_f2_s3", digit, 4'h5);
    chk("hv_ready_end", value_ready, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
